md_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting beside the ALU in the execute stage. It accepts one signed or unsigned multiply/divide per start pulse and holds `busy` for a fixed, op-dependent latency, then commits results to HI/LO. It also services single-cycle HI/LO writes. The pipeline controller stalls any HI/LO-dependent instruction in execute while `busy` is high.

---
 rtl/md_unit_pkg.sv | 28 ++
 rtl/md_core.sv | 89 ++++++++
 rtl/md_unit.sv | 94 +++++++++
 tb/tb_md_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared op codes and state encoding for the execute-stage multiply/divide unit.
package md_unit_pkg;

  localparam int MD_OP_LEN = 3;

  localparam logic [MD_OP_LEN-1:0] MD_OP_MULT  = 3'd0;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MULTU = 3'd1;
  localparam logic [MD_OP_LEN-1:0] MD_OP_DIV   = 3'd2;
  localparam logic [MD_OP_LEN-1:0] MD_OP_DIVU  = 3'd3;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MTHI  = 3'd4;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_arith_op(input logic [MD_OP_LEN-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_LEN-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one op,
// including the zero-divisor and signed-overflow cases.
module md_core
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_LEN-1:0] op,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  output logic [WIDTH-1:0]     res_hi,
  output logic [WIDTH-1:0]     res_lo
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0]   a_s;
  logic signed [WIDTH-1:0]   b_s;
  logic signed [2*WIDTH-1:0] a_x;
  logic signed [2*WIDTH-1:0] b_x;
  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic                      div_zero;
  logic                      div_ovf;
  logic [WIDTH-1:0]          divisor_nz;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]          quot_u;
  logic [WIDTH-1:0]          rem_u;

  assign a_s    = in0;
  assign b_s    = in1;
  assign a_x    = a_s;
  assign b_x    = b_s;
  assign prod_s = a_x * b_x;
  assign prod_u = {{WIDTH{1'b0}}, in0} * {{WIDTH{1'b0}}, in1};

  // Zero divisor is replaced by 1 so the dividers never see an undefined case;
  // the real result for that case is selected below.
  assign div_zero   = (in1 == '0);
  assign div_ovf    = (in0 == MOST_NEG) && (in1 == '1);
  assign divisor_nz = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : in1;

  assign quot_s = a_s / $signed(divisor_nz);
  assign rem_s  = a_s % $signed(divisor_nz);
  assign quot_u = in0 / divisor_nz;
  assign rem_u  = in0 % divisor_nz;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_OP_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      MD_OP_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      MD_OP_DIV: begin
        if (div_zero) begin
          res_hi = in0;
          res_lo = '1;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = MOST_NEG;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      MD_OP_DIVU: begin
        if (div_zero) begin
          res_hi = in0;
          res_lo = '1;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO: results are computed at start,
// held in pending registers and committed after a fixed op-dependent latency.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MD_OP_LEN-1:0] op,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  output logic                 busy,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] pending_hi_reg;
  logic [WIDTH-1:0] pending_lo_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;

  md_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (op),
    .in0    (in0),
    .in1    (in1),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= MD_IDLE;
      cnt_reg        <= '0;
      pending_hi_reg <= '0;
      pending_lo_reg <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (start) begin
            if (is_arith_op(op)) begin
              pending_hi_reg <= core_hi;
              pending_lo_reg <= core_lo;
              cnt_reg        <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
              state_reg      <= MD_RUN;
              busy_reg       <= 1'b1;
            end else if (op == MD_OP_MTHI) begin
              hi_reg <= in0;
            end else if (op == MD_OP_MTLO) begin
              lo_reg <= in0;
            end
          end
        end
        MD_RUN: begin
          // Requests arriving while running are dropped, MTHI/MTLO included.
          if (cnt_reg == CNT_W'(1)) begin
            hi_reg    <= pending_hi_reg;
            lo_reg    <= pending_lo_reg;
            cnt_reg   <= '0;
            state_reg <= MD_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= MD_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios then random traffic, every cycle
// compared against a timestamp-based reference model of the unit.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [MD_OP_LEN-1:0] op;
  logic [WIDTH-1:0]     in0;
  logic [WIDTH-1:0]     in1;
  logic                 busy;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;

  int total = 0;
  int bad   = 0;

  // Reference model: results live in m_hi/m_lo; an in-flight op is a pending
  // pair plus the absolute edge number at which it commits (-1 = none).
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  longint      edge_no;
  longint      commit_edge;

  md_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .in0   (in0),
    .in1   (in1),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  function automatic void ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rhi, output logic [31:0] rlo);
    int              sa, sb, q;
    longint          ps;
    longint unsigned ua, ub, pu;
    sa = a; sb = b;
    ua = a; ub = b;
    rhi = 0; rlo = 0;
    if (o == MD_OP_MULT) begin
      ps = longint'(sa) * longint'(sb);
      rhi = ps[63:32]; rlo = ps[31:0];
    end else if (o == MD_OP_MULTU) begin
      pu = ua * ub;
      rhi = pu[63:32]; rlo = pu[31:0];
    end else if (b == 0) begin
      rhi = a; rlo = 32'hFFFF_FFFF;
    end else if (o == MD_OP_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        rhi = 0; rlo = 32'h8000_0000;
      end else begin
        q = sa / sb;
        rlo = q;
        rhi = sa - q * sb;
      end
    end else begin
      rlo = a / b;
      rhi = a - (a / b) * b;
    end
  endfunction

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cycle(input logic r, input logic s, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    logic        was_busy;
    logic [31:0] rh, rl;
    reset = r; start = s; op = o; in0 = a; in1 = b;
    was_busy = (commit_edge >= 0);
    @(posedge clk);
    edge_no++;
    if (r) begin
      m_hi = 0; m_lo = 0; commit_edge = -1;
    end else if (was_busy) begin
      if (edge_no == commit_edge) begin
        m_hi = m_pend_hi; m_lo = m_pend_lo; commit_edge = -1;
      end
    end else if (s) begin
      if (o <= MD_OP_DIVU) begin
        ref_md(o, a, b, rh, rl);
        m_pend_hi = rh; m_pend_lo = rl;
        commit_edge = edge_no + ((o == MD_OP_DIV || o == MD_OP_DIVU) ? DIV_CYCLES : MUL_CYCLES);
      end else if (o == MD_OP_MTHI) begin
        m_hi = a;
      end else if (o == MD_OP_MTLO) begin
        m_lo = a;
      end
    end
    #1;
    check("busy", 64'(busy), 64'(commit_edge >= 0));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, MD_OP_MULT, 32'h0, 32'h0);
  endtask

  // Runs idle cycles until busy drops; returns how many cycles busy was seen.
  task automatic drain(output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (!busy) return;
      n++;
    end
    check("drain_timeout", 64'(busy), 64'(0));
  endtask

  task automatic directed(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo);
    int n;
    cycle(1'b0, 1'b1, o, a, b);
    drain(n);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    $display("txn %s: busy_cycles=%0d hi=0x%08h lo=0x%08h", tag, n, hi, lo);
  endtask

  initial begin
    int          n;
    logic [31:0] a, b;
    logic [31:0] specials [5];
    specials = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF};
    edge_no = 0; commit_edge = -1;
    m_hi = 0; m_lo = 0; m_pend_hi = 0; m_pend_lo = 0;
    reset = 1'b1; start = 1'b0; op = '0; in0 = '0; in1 = '0;

    cycle(1'b1, 1'b1, MD_OP_MTHI, 32'hDEAD, 32'h0);
    cycle(1'b1, 1'b0, MD_OP_MULT, 32'h0, 32'h0);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    $display("txn reset: busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

    directed("mult_neg", MD_OP_MULT, -32'sd3, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    directed("multu_max", MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h1);
    directed("div_neg", MD_OP_DIV, -32'sd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    directed("divu_zero", MD_OP_DIVU, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF);
    directed("div_ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    // drain() ended in the cycle busy fell, so this start is back-to-back.
    directed("divu_b2b", MD_OP_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    cycle(1'b0, 1'b1, MD_OP_MTHI, 32'h1234, 32'h0);
    check("mthi_hi", 64'(hi), 64'(32'h1234));
    check("mthi_busy", 64'(busy), 64'(0));
    $display("txn mthi: hi=0x%08h busy=%0d", hi, busy);

    cycle(1'b0, 1'b1, MD_OP_MULT, 32'd3, 32'd4);
    cycle(1'b0, 1'b1, MD_OP_MTLO, 32'h55, 32'h0);
    drain(n);
    check("mtlo_ignored_lo", 64'(lo), 64'(32'd12));
    $display("txn mtlo_during_mult: lo=0x%08h", lo);

    cycle(1'b0, 1'b1, MD_OP_DIV, 32'd1000, 32'd3);
    idle();
    idle();
    cycle(1'b1, 1'b0, MD_OP_MULT, 32'h0, 32'h0);
    check("abort_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 12; i++) idle();
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    $display("txn reset_abort: busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), a, b);
    end
    $display("txn random: edges=%0d", edge_no);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
